pipe_skid_rx: RTL and testbench

PIPE_SKID_RX -- requirements
Module: pipe_skid_rx

---
 rtl/pipe_skid_rx.sv | 117 +++++++++++
 tb/tb_pipe_skid_rx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_skid_rx.sv
// rtl/pipe_skid_rx.sv - receive-side skid buffer for a fixed-latency pipelined path
//
// Purpose: absorbs every word arriving on in_vld/in_data into a DEPTH-entry
// first-word-fall-through buffer, and raises a registered stop once occupancy
// reaches DEPTH-SKID_NUM so upstream halts while in-flight words still fit.
// Words arriving into a full buffer with no simultaneous pop are dropped and
// flagged via the sticky ovf_err.
//
// Optional feature: define PIPE_SKID_OVF_CNT_EN to enable the saturating
// 16-bit drop counter on ovf_cnt; otherwise ovf_cnt is tied to zero.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   in_vld    in   upstream word valid (no backpressure)
//   in_data   in   upstream word [DWID]
//   stop      out  registered halt request to upstream
//   out_vld   out  buffer non-empty
//   out_data  out  head-of-buffer word [DWID]
//   out_rdy   in   downstream accepts head word
//   level     out  occupancy 0..DEPTH [AWID+1]
//   ovf_err   out  sticky overflow flag
//   ovf_cnt   out  overflow drop counter [16]

module pipe_skid_rx #(
  parameter int DWID     = 10,
  parameter int AWID     = 3,
  parameter int SKID_NUM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic [DWID-1:0] in_data,
  output logic            stop,
  output logic            out_vld,
  output logic [DWID-1:0] out_data,
  input  logic            out_rdy,
  output logic [AWID:0]   level,
  output logic            ovf_err,
  output logic [15:0]     ovf_cnt
);

  localparam int DEPTH = 1 << AWID;
  localparam logic [AWID:0] STOP_TH = (AWID+1)'(DEPTH - SKID_NUM);

  logic [DWID-1:0] mem [DEPTH];
  logic [AWID:0]   wr_ptr;
  logic [AWID:0]   rd_ptr;
  logic [AWID:0]   wr_nxt;
  logic [AWID:0]   rd_nxt;
  logic [AWID:0]   level_next;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            drop;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign full  = (wr_ptr[AWID] != rd_ptr[AWID]) &&
                 (wr_ptr[AWID-1:0] == rd_ptr[AWID-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Occupancy falls out of the pointer difference; this also makes level and
  // out_vld drop to zero the moment reset clears the pointers.
  assign level    = wr_ptr - rd_ptr;
  assign out_vld  = !empty;
  assign out_data = mem[rd_ptr[AWID-1:0]];

  assign pop  = out_vld && out_rdy;
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign push = in_vld && (!full || pop);
  assign drop = in_vld && full && !pop;

  assign wr_nxt     = wr_ptr + (AWID+1)'(push);
  assign rd_nxt     = rd_ptr + (AWID+1)'(pop);
  assign level_next = wr_nxt - rd_nxt;

  // Storage carries no reset; contents behind an empty pointer pair are dead.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr[AWID-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      stop    <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      stop   <= (level_next >= STOP_TH);
      if (drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

`ifdef PIPE_SKID_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= 16'h0000;
    end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'h0001;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_rx.sv
// tb/tb_pipe_skid_rx.sv - self-checking bench for pipe_skid_rx against a queue model

module tb_pipe_skid_rx;

  localparam int DWID  = 10;
  localparam int AWID  = 3;
  localparam int DEPTH = 8;
  localparam int SKID  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld;
  logic [DWID-1:0] in_data;
  logic            stop;
  logic            out_vld;
  logic [DWID-1:0] out_data;
  logic            out_rdy;
  logic [AWID:0]   level;
  logic            ovf_err;
  logic [15:0]     ovf_cnt;

  pipe_skid_rx #(.DWID(DWID), .AWID(AWID), .SKID_NUM(SKID)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .stop(stop),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy), .level(level),
    .ovf_err(ovf_err), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DWID-1:0] q[$];
  logic [DWID-1:0] popped[$];
  logic            err_m;
  int              cnt_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer.
  task automatic chk_all(input string tag);
    int exp_cnt;
`ifdef PIPE_SKID_OVF_CNT_EN
    exp_cnt = cnt_m;
`else
    exp_cnt = 0;
`endif
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".out_vld"}, 32'(out_vld), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
    chk({tag, ".stop"}, 32'(stop), 32'(q.size() >= DEPTH - SKID));
    chk({tag, ".ovf_err"}, 32'(ovf_err), 32'(err_m));
    chk({tag, ".ovf_cnt"}, 32'(ovf_cnt), 32'(exp_cnt));
  endtask

  // One clock: apply inputs, advance the model over the edge, then check.
  task automatic step(input logic v, input logic [DWID-1:0] d, input logic r, input string tag);
    bit do_pop;
    in_vld  = v;
    in_data = d;
    out_rdy = r;
    @(posedge clk);
    do_pop = r && (q.size() != 0);
    if (do_pop) popped.push_back(q.pop_front());
    if (v) begin
      if (q.size() < DEPTH) q.push_back(d);
      else begin
        err_m = 1'b1;
        if (cnt_m < 16'hFFFF) cnt_m++;
      end
    end
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    popped.delete();
    err_m = 1'b0;
    cnt_m = 0;
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, "idle");

    // Single word with immediate consumption.
    step(1'b1, 10'h155, 1'b1, "one_push");
    chk("one_push.data", 32'(out_data), 32'h155);
    step(1'b0, '0, 1'b1, "one_pop");
    chk("one_pop.level", 32'(level), 32'd0);

    // stop threshold: asserted after 4th push, not after 3rd.
    for (int i = 0; i < 4; i++) step(1'b1, 10'(i + 16), 1'b0, "thresh");
    chk("thresh.stop4", 32'(stop), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "thresh_drain");

    // Overflow: 10 words into a stalled buffer, then drain in order.
    for (int i = 0; i < 10; i++) step(1'b1, 10'(i), 1'b0, "ovf_fill");
    chk("ovf.level", 32'(level), 32'd8);
    popped.delete();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "ovf_drain");
    for (int i = 0; i < 8; i++) chk("ovf.order", 32'(popped[i]), 32'(i));

    // Push into full buffer with simultaneous pop: accepted, no error.
    rst = 1'b1; #1; model_reset(); chk_all("rst2");
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 10'(i + 32), 1'b0, "full_fill");
    step(1'b1, 10'h3AA, 1'b1, "full_pushpop");
    chk("full_pushpop.level", 32'(level), 32'd8);
    chk("full_pushpop.err", 32'(ovf_err), 32'd0);

    // Continuous flow through pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 10'(i + 100), 1'b1, "stream");
    chk("stream.level", 32'(level), 32'd8);

    // Async reset with level=5 and stop=1, in_vld held during reset.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "to5");
    chk("to5.level", 32'(level), 32'd5);
    #2;
    rst = 1'b1; in_vld = 1'b1; in_data = 10'h2C3;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk); #1;
    chk_all("rst_invld");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, "post_rst");
    step(1'b1, 10'h0F0, 1'b0, "post_push");
    chk("post_push.data", 32'(out_data), 32'h0F0);
    step(1'b0, '0, 1'b1, "post_pop");

    // Randomized traffic biased toward filling so overflows occur.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 1) == 1, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
